// File: rtl/wb_byte_bridge.sv
// Byte-serial host port to classic Wishbone master: shifts in cmd/addr/wdata,
// runs one bus cycle with timeout, then streams read data back a byte at a time.
module wb_byte_bridge #(
  parameter int ADR_W   = 14,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         host_dat_i,
  input  logic               host_strobe,
  output logic               host_ready,
  output logic [7:0]         host_dat_o,
  output logic               host_valid,
  input  logic               host_rd_ack,
  output logic               host_err,
  output logic               wb_CYC,
  output logic               wb_STB,
  output logic               wb_WE,
  output logic [ADR_W-1:0]   wb_ADR,
  output logic [DAT_W-1:0]   wb_DAT_MOSI,
  output logic [DAT_W/8-1:0] wb_SEL,
  input  logic               wb_ACK,
  input  logic [DAT_W-1:0]   wb_DAT_MISO
);

  localparam int NA    = (ADR_W + 7) / 8;
  localparam int ND    = DAT_W / 8;
  localparam int SEL_W = ND;
  localparam logic [1:0] NA_LAST  = 2'(NA - 1);
  localparam logic [1:0] ND_LAST  = 2'(ND - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_BUS, S_RDATA} state_t;

  typedef struct packed {
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } req_t;

  state_t           state;
  req_t             req;
  logic [1:0]       idx;
  logic [7:0]       tmo;
  logic [DAT_W-1:0] rd_q;

  // Byte i of the shift-in lands at bits [8i+7:8i]; bits past the field width fall off.
  function automatic logic [ADR_W-1:0] put_adr(input logic [ADR_W-1:0] cur,
                                               input logic [1:0] i, input logic [7:0] b);
    logic [ADR_W-1:0] r;
    r = cur;
    for (int k = 0; k < ADR_W; k++)
      if (i == 2'(k / 8)) r[k] = b[k % 8];
    return r;
  endfunction

  function automatic logic [DAT_W-1:0] put_dat(input logic [DAT_W-1:0] cur,
                                               input logic [1:0] i, input logic [7:0] b);
    logic [DAT_W-1:0] r;
    r = cur;
    for (int k = 0; k < DAT_W; k++)
      if (i == 2'(k / 8)) r[k] = b[k % 8];
    return r;
  endfunction

  assign wb_ADR      = req.adr;
  assign wb_DAT_MOSI = req.dat;
  assign wb_SEL      = req.sel;
  assign host_dat_o  = rd_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CMD;
      req        <= '0;
      idx        <= '0;
      tmo        <= '0;
      rd_q       <= '0;
      host_ready <= 1'b1;
      host_valid <= 1'b0;
      host_err   <= 1'b0;
      wb_CYC     <= 1'b0;
      wb_STB     <= 1'b0;
      wb_WE      <= 1'b0;
    end else begin
      case (state)
        S_CMD: if (host_strobe) begin
          req.we   <= host_dat_i[7];
          req.sel  <= host_dat_i[SEL_W-1:0];
          host_err <= 1'b0;
          idx      <= '0;
          state    <= S_ADDR;
        end
        S_ADDR: if (host_strobe) begin
          req.adr <= put_adr(req.adr, idx, host_dat_i);
          if (idx == NA_LAST) begin
            idx <= '0;
            if (req.we) state <= S_WDATA;
            else begin
              state      <= S_BUS;
              wb_CYC     <= 1'b1;
              wb_STB     <= 1'b1;
              wb_WE      <= 1'b0;
              host_ready <= 1'b0;
              tmo        <= '0;
            end
          end else begin
            idx <= idx + 2'd1;
          end
        end
        S_WDATA: if (host_strobe) begin
          req.dat <= put_dat(req.dat, idx, host_dat_i);
          if (idx == ND_LAST) begin
            idx        <= '0;
            state      <= S_BUS;
            wb_CYC     <= 1'b1;
            wb_STB     <= 1'b1;
            wb_WE      <= 1'b1;
            host_ready <= 1'b0;
            tmo        <= '0;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        S_BUS: begin
          // ACK is checked first so an ACK on the timeout edge still completes.
          if (wb_ACK) begin
            wb_CYC <= 1'b0;
            wb_STB <= 1'b0;
            wb_WE  <= 1'b0;
            if (req.we) begin
              state      <= S_CMD;
              host_ready <= 1'b1;
            end else begin
              rd_q       <= wb_DAT_MISO;
              host_valid <= 1'b1;
              idx        <= '0;
              state      <= S_RDATA;
            end
          end else if (TIMEOUT != 0 && tmo == TMO_LAST) begin
            wb_CYC     <= 1'b0;
            wb_STB     <= 1'b0;
            wb_WE      <= 1'b0;
            host_err   <= 1'b1;
            host_ready <= 1'b1;
            state      <= S_CMD;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        S_RDATA: if (host_rd_ack) begin
          if (idx == ND_LAST) begin
            host_valid <= 1'b0;
            host_ready <= 1'b1;
            state      <= S_CMD;
          end else begin
            rd_q <= rd_q >> 8;
            idx  <= idx + 2'd1;
          end
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: doc/wb_byte_bridge.md
# wb_byte_bridge

Parametrised byte-serial host-to-Wishbone bridge. It replaces the fixed XOR fan-out of the 8-bit `ui_in` pins onto `wb_ADR` and `wb_DAT_MOSI` with a real transaction engine. An 8-bit host port shifts in a command byte, address and write data, and the bridge runs exactly one classic Wishbone cycle into `UsbDeviceTop`. Read data is returned byte-serially, and a bus timeout is reported. It sits in the Tiny Tapeout top level between the `ui_in`/`uo_out`/`uio` pins and the USB device's `wb_*` port.

## Interface
Parameters:
- `ADR_W`, default 14: Wishbone address width, 1..32. `NA = ceil(ADR_W/8)` address bytes.
- `DAT_W`, default 32: Wishbone data width, one of 8/16/32. `ND = DAT_W/8` data bytes; `SEL_W = ND`.
- `TIMEOUT`, default 255: maximum cycles STB is held without ACK, 1..255. 0 disables the timeout.

Ports:
- `clk` in 1: single clock (ctrlCd domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `host_dat_i` in 8: command/address/write-data byte.
- `host_strobe` in 1: byte valid; accepted on a cycle where `host_strobe && host_ready`.
- `host_ready` out 1: bridge can accept a byte.
- `host_dat_o` out 8: read-data byte.
- `host_valid` out 1: `host_dat_o` valid.
- `host_rd_ack` in 1: host consumed `host_dat_o`; effective only while `host_valid`.
- `host_err` out 1: sticky timeout flag.
- `wb_CYC`, `wb_STB`, `wb_WE` out 1: Wishbone master controls.
- `wb_ADR` out ADR_W, `wb_DAT_MOSI` out DAT_W, `wb_SEL` out SEL_W: Wishbone master outputs.
- `wb_ACK` in 1, `wb_DAT_MISO` in DAT_W: Wishbone slave response.

## Operation
- States: CMD, ADDR, WDATA, BUS, RDATA. Reset enters CMD.
- **CMD**
  - Accepted byte: bit7 = WE, bits[SEL_W-1:0] = SEL; other bits are ignored.
  - Accepting a command clears `host_err`.
  - Next state is ADDR, byte index = 0.
- **ADDR**
  - Accepts NA bytes, LSB first, into `wb_ADR`. Bits above ADR_W in the last byte are discarded.
  - After the last byte: WE=1 goes to WDATA, WE=0 goes to BUS.
- **WDATA**
  - Accepts ND bytes, LSB first, into `wb_DAT_MOSI`.
  - After the last byte, goes to BUS.
- **BUS**
  - `wb_CYC = wb_STB = 1` and `wb_WE = WE`.
  - `wb_ADR`, `wb_SEL`, `wb_DAT_MOSI` are held stable for the whole BUS state.
  - On a cycle with `wb_ACK` = 1: `wb_DAT_MISO` is captured (read only). Next state is RDATA for a read, CMD for a write.
  - On timeout: next state is CMD, `host_err` = 1, and no read data is returned.
- **RDATA**
  - Presents the captured data LSB byte first, `host_valid` = 1.
  - Each `host_rd_ack` advances to the next byte. The ack on the last byte goes to CMD.
- `host_ready` = 1 only in CMD, ADDR and WDATA.
- `host_strobe` is ignored in BUS and RDATA.
- `wb_ACK` is ignored outside BUS.
- There is no abort. Only reset abandons a transaction.
- Reset mid-transaction returns to CMD and discards all partial bytes.

## Timing
- Reset values:
  - `host_ready` = 1.
  - `host_valid`, `host_err`, `wb_CYC`, `wb_STB`, `wb_WE` = 0.
  - `host_dat_o`, `wb_ADR`, `wb_DAT_MOSI`, `wb_SEL` = 0.
- All outputs are registered. No combinational path runs from `wb_ACK` or `host_*` inputs to any output.
- One byte per cycle maximum. The host may hold `host_strobe` high continuously.
- Last byte accepted on edge N: `wb_CYC`/`wb_STB` rise after edge N, and `host_ready` falls after edge N.
- `wb_ACK` sampled high at edge M:
  - `wb_CYC`/`wb_STB` fall after edge M, so there is no second cycle even if the slave holds ACK.
  - Read: `host_valid` rises after edge M, with byte 0 on `host_dat_o`.
  - Write: `host_ready` rises after edge M.
- `host_rd_ack` at edge K (not the last byte): the next byte appears after edge K, and `host_valid` stays high.
- `host_rd_ack` at edge K (last byte): `host_valid` falls and `host_ready` rises after edge K.
- Timeout:
  - The counter resets on BUS entry and increments each BUS cycle without ACK.
  - If STB has been high for TIMEOUT cycles with no ACK sampled, STB/CYC drop after that TIMEOUT-th edge and `host_err` rises.
  - ACK on the same edge as the timeout: ACK wins and `host_err` stays 0.
- Minimum write latency (ADR_W=14, DAT_W=32) is 7 host bytes plus 1 cycle of Wishbone with a zero-wait slave.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-ADDR. Required:
  - All outputs at their reset values within the same cycle (asynchronous).
  - `host_ready` = 1 after release.
  - A fresh command works.
- **Write:** bytes 0x8F, 0x34, 0x12, 0xEF, 0xBE, 0xAD, 0xDE; slave ACKs on its 3rd STB cycle. Required:
  - `wb_ADR` = 0x1234 (14-bit).
  - `wb_DAT_MOSI` = 0xDEADBEEF, `wb_SEL` = 0xF, `wb_WE` = 1.
  - STB high for exactly 3 cycles.
  - `host_ready` back high the cycle after ACK.
- **Read:** bytes 0x03, 0x10, 0x00; slave returns 0xCAFEF00D with zero-wait ACK. Required:
  - `wb_SEL` = 0x3, `wb_WE` = 0.
  - Output bytes 0x0D, 0xF0, 0xFE, 0xCA, each held until `host_rd_ack`, including across 2-cycle ack gaps.
- **Timeout:** TIMEOUT=4, read with the slave never ACKing. Required:
  - STB high exactly 4 cycles, then `host_err` = 1 and `host_valid` never asserted.
  - The next command byte clears `host_err`.
- **Boundaries:**
  - ACK on the exact timeout edge leaves `host_err` = 0 and read data is returned.
  - A slave holding ACK high for 5 cycles produces exactly one STB pulse.
  - `host_strobe` pulsed during RDATA is ignored and the byte index is unchanged.
- **Parameter sweep:** rerun the write/read scenarios with ADR_W=8/DAT_W=8 (NA=1, ND=1, SEL_W=1) and ADR_W=20/DAT_W=16 (NA=3, ND=2; address upper nibble truncated).
